dpram_read_stream: RTL and testbench

Read-side streamer for the byte-enable dual-port RAM's read port (port B, 1-cycle read latency, always enabled). It accepts a start address and word count, issues sequential port-B reads, and delivers the words on a valid/ready stream with a last marker. A small first-word-fall-through FIFO absorbs the RAM latency and downstream backpressure, so no read result is ever lost.

---
 rtl/dpram_read_stream.sv | 166 ++++++++++++++++
 tb/tb_dpram_read_stream.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_read_stream.sv
// dpram_read_stream: walks a run of RAM port-B addresses and delivers the read
// words on a valid/ready stream, absorbing read latency and backpressure in a
// small first-word-fall-through FIFO.
module dpram_read_stream #(
    parameter int unsigned widthad    = 10,
    parameter int unsigned width      = 32,
    parameter int unsigned fifo_depth = 4
) (
    input  logic               clock_in,
    input  logic               reset_in,
    input  logic               start,
    input  logic [widthad-1:0] start_addr,
    input  logic [widthad:0]   len,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic [widthad-1:0] ram_address_b,
    input  logic [width-1:0]   ram_q_b,
    output logic               out_valid,
    output logic [width-1:0]   out_data,
    output logic               out_last,
    input  logic               out_ready
);
    localparam int unsigned PTR_W = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned LEN_W = widthad + 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [LEN_W-1:0]      issue_rem;
    logic [LEN_W-1:0]      out_rem;
    logic                  inflight;
    logic                  inflight_last;
    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W-1:0]      fifo_count_nxt;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [width-1:0]      fifo_data [fifo_depth];
    logic [fifo_depth-1:0] fifo_last;

    logic load;
    logic issue;
    logic push;
    logic pop;
    logic flush;
    logic finish;
    logic zero_len;

    // Head of the FIFO is presented directly (fall-through).
    assign out_data = fifo_data[rd_ptr];
    assign out_last = fifo_last[rd_ptr];

    // State register.
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-cycle control; a read is issued only while the
    // FIFO plus the read still in the RAM pipe leaves room for its result.
    always_comb begin
        state_nxt      = state;
        load           = 1'b0;
        issue          = 1'b0;
        flush          = 1'b0;
        finish         = 1'b0;
        zero_len       = 1'b0;
        push           = inflight;
        pop            = out_valid && out_ready;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        load      = 1'b1;
                        state_nxt = S_RUN;
                    end else begin
                        zero_len = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    flush     = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    issue = (issue_rem != '0) &&
                            ((fifo_count + CNT_W'(inflight)) < CNT_W'(fifo_depth));
                    if (pop && (out_rem == LEN_W'(1))) begin
                        finish    = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        fifo_count_nxt = fifo_count + CNT_W'(push) - CNT_W'(pop);
    end

    // Address/counter datapath, read pipeline tracking and FIFO storage.
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            busy          <= 1'b0;
            done          <= 1'b0;
            ram_address_b <= '0;
            issue_rem     <= '0;
            out_rem       <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            fifo_count    <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            out_valid     <= 1'b0;
            fifo_last     <= '0;
            for (int unsigned i = 0; i < fifo_depth; i++) begin
                fifo_data[i] <= '0;
            end
        end else begin
            busy <= (state_nxt == S_RUN);
            done <= finish || zero_len;

            if (load) begin
                ram_address_b <= start_addr;
                issue_rem     <= len;
                out_rem       <= len;
            end else begin
                if (issue) begin
                    ram_address_b <= ram_address_b + widthad'(1);
                    issue_rem     <= issue_rem - LEN_W'(1);
                end
                if (pop) begin
                    out_rem <= out_rem - LEN_W'(1);
                end
            end

            inflight      <= issue;
            inflight_last <= issue && (issue_rem == LEN_W'(1));

            if (flush) begin
                fifo_count <= '0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                out_valid  <= 1'b0;
            end else begin
                if (push) begin
                    fifo_data[wr_ptr] <= ram_q_b;
                    fifo_last[wr_ptr] <= inflight_last;
                    wr_ptr            <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                fifo_count <= fifo_count_nxt;
                out_valid  <= (fifo_count_nxt != '0);
            end
        end
    end

endmodule

// File: tb/tb_dpram_read_stream.sv
// Testbench for dpram_read_stream: a 1-cycle-latency RAM model, a stimulus
// thread that queues the expected word stream for each accepted transfer,
// and a monitor that checks every handshake, stall hold, credit and done.
module tb_dpram_read_stream;

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_in;
    logic        start;
    logic [9:0]  start_addr;
    logic [10:0] len;
    logic        abort;
    logic        busy;
    logic        done;
    logic [9:0]  ram_address_b;
    logic [31:0] ram_q_b;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_ready = 1'b1;

    logic [31:0] mem [1024];
    exp_t        sb [$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rmode = 0;
    int          rphase = 0;

    logic        acc = 1'b0;
    logic [9:0]  acc_addr = '0;
    logic        acc_zl = 1'b0;

    dpram_read_stream #(
        .widthad   (10),
        .width     (32),
        .fifo_depth(4)
    ) dut (
        .clock_in     (clk),
        .reset_in     (reset_in),
        .start        (start),
        .start_addr   (start_addr),
        .len          (len),
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .ram_address_b(ram_address_b),
        .ram_q_b      (ram_q_b),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_last     (out_last),
        .out_ready    (out_ready)
    );

    always #5 clk = ~clk;

    // RAM port B: registered read, one cycle of latency.
    always @(posedge clk) ram_q_b <= mem[ram_address_b];

    always @(posedge clk) cyc <= cyc + 1;

    // Note every start the design is obliged to accept.
    always @(posedge clk) begin
        acc      <= reset_in && start && !busy;
        acc_addr <= start_addr;
        acc_zl   <= (len == 11'd0);
    end

    // Downstream ready patterns: always, 1-0-0 toggle, random, never.
    always @(posedge clk) begin
        #1;
        case (rmode)
            0: out_ready = 1'b1;
            1: begin
                out_ready = (rphase == 0);
                rphase    = (rphase == 2) ? 0 : rphase + 1;
            end
            2: out_ready = ($urandom_range(0, 99) < 65);
            default: out_ready = 1'b0;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard.
    logic        done_due = 1'b0;
    logic        stall_prev = 1'b0;
    logic [31:0] held_data;
    logic        held_last;
    logic [9:0]  cur_start = '0;
    int          pops = 0;

    always @(negedge clk) begin : mon
        exp_t e;
        int   outst;
        if (!reset_in) begin
            sb.delete();
            done_due   = 1'b0;
            stall_prev = 1'b0;
        end else begin
            chk("done_pulse", done, done_due || (acc && acc_zl));
            done_due = 1'b0;
            if (acc) begin
                cur_start = acc_addr;
                pops      = 0;
            end
            if (busy) begin
                outst = int'(10'(ram_address_b - cur_start)) - pops;
                if (outst > 4) chk("credit_outstanding", 64'(outst), 64'd4);
                else checks++;
            end
            if (stall_prev) begin
                chk("stall_hold", {out_valid, out_last, out_data}, {1'b1, held_last, held_data});
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL stream_word: got unexpected data 0x%0h last %0b, expected no word",
                             out_data, out_last);
                end else begin
                    e = sb.pop_front();
                    if (out_data !== e.data || out_last !== e.last) begin
                        errors++;
                        $display("FAIL stream_word: got data 0x%0h last %0b, expected data 0x%0h last %0b",
                                 out_data, out_last, e.data, e.last);
                    end
                    if (e.last) done_due = 1'b1;
                end
                pops++;
            end
            stall_prev = out_valid && !out_ready;
            held_data  = out_data;
            held_last  = out_last;
            if (abort && busy) begin
                sb.delete();
                done_due   = 1'b0;
                stall_prev = 1'b0;
            end
        end
    end

    task automatic push_exp(input logic [9:0] a, input logic [10:0] l);
        exp_t e;
        for (int k = 0; k < int'(l); k++) begin
            e.last = (k == int'(l) - 1);
            e.data = mem[10'(int'(a) + k)];
            sb.push_back(e);
        end
    endtask

    task automatic start_xfer(input logic [9:0] a, input logic [10:0] l, input bit ab, output int t0);
        @(posedge clk);
        #1;
        start = 1'b1; start_addr = a; len = l; abort = ab;
        push_exp(a, l);
        t0 = cyc;
        @(posedge clk);
        #1;
        start = 1'b0; abort = 1'b0;
    endtask

    // Drive a start in the current cycle (called from a negedge).
    task automatic start_now(input logic [9:0] a, input logic [10:0] l, output int t0);
        #1;
        start = 1'b1; start_addr = a; len = l;
        push_exp(a, l);
        t0 = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic observe(input int t0, input int maxc, input bit stop_at_done,
                           output int fv, output int lc, output int dc,
                           output bit saw_busy, output bit saw_valid);
        fv = -1; lc = -1; dc = -1; saw_busy = 1'b0; saw_valid = 1'b0;
        for (int n = 0; n < maxc; n++) begin
            @(negedge clk);
            if (busy) saw_busy = 1'b1;
            if (out_valid) saw_valid = 1'b1;
            if (out_valid && fv < 0) fv = cyc - t0;
            if (out_valid && out_ready && out_last) lc = cyc - t0;
            if (done && dc < 0) dc = cyc - t0;
            if (done && stop_at_done) break;
        end
    endtask

    task automatic wait_idle(input bit spur);
        int n = 0;
        while ((busy || out_valid || sb.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
            if (spur && busy && $urandom_range(0, 7) == 0) begin
                start      = 1'b1;
                start_addr = 10'($urandom);
                len        = 11'($urandom_range(0, 50));
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("idle_reached", n < 3000, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int fv;
        int lc;
        int dc;
        bit sbz;
        bit svz;
        logic [9:0]  a;
        logic [10:0] l;

        reset_in = 1'b0; start = 1'b0; abort = 1'b0; start_addr = '0; len = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'(i);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_valid", out_valid, 1'b0);
        chk("reset_data", out_data, 32'h0);
        chk("reset_last", out_last, 1'b0);
        chk("reset_addr", ram_address_b, 10'h0);
        #2 reset_in = 1'b1;
        repeat (2) @(posedge clk);

        // Basic transfer, full throughput.
        start_xfer(10'h010, 11'd4, 1'b0, t0);
        observe(t0, 10, 1'b0, fv, lc, dc, sbz, svz);
        chk("t1_first_valid_cycle", 64'(fv), 64'd3);
        chk("t1_last_cycle", 64'(lc), 64'd6);
        chk("t1_done_cycle", 64'(dc), 64'd7);
        wait_idle(1'b0);

        // Same transfer with 1,0,0 backpressure and an ignored start while busy.
        rmode = 1;
        start_xfer(10'h010, 11'd4, 1'b0, t0);
        @(posedge clk);
        #1;
        start = 1'b1; start_addr = 10'h200; len = 11'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle(1'b0);
        rmode = 0;
        repeat (2) @(posedge clk);

        // Address wrap, start together with abort while idle, then back-to-back start.
        start_xfer(10'h3FE, 11'd4, 1'b1, t0);
        observe(t0, 12, 1'b1, fv, lc, dc, sbz, svz);
        chk("wrap_last_cycle", 64'(lc), 64'd6);
        chk("wrap_done_cycle", 64'(dc), 64'd7);
        start_now(10'h020, 11'd2, t0);
        observe(t0, 10, 1'b1, fv, lc, dc, sbz, svz);
        chk("b2b_first_valid_cycle", 64'(fv), 64'd3);
        chk("b2b_done_cycle", 64'(dc), 64'd5);
        wait_idle(1'b0);

        // Abort with the FIFO full and the stream stalled.
        rmode = 3;
        repeat (2) @(posedge clk);
        start_xfer(10'h040, 11'd8, 1'b0, t0);
        while (cyc < t0 + 5) begin
            @(posedge clk);
            #1;
        end
        abort = 1'b1;
        @(negedge clk);
        chk("abort_credit_addr", ram_address_b, 10'h044);
        chk("abort_valid_before", out_valid, 1'b1);
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_valid_after", out_valid, 1'b0);
        chk("abort_busy_after", busy, 1'b0);
        observe(t0, 5, 1'b0, fv, lc, dc, sbz, svz);
        chk("abort_no_done", 64'(dc), 64'(-1));
        rmode = 0;
        @(posedge clk);
        start_xfer(10'h000, 11'd1, 1'b0, t0);
        wait_idle(1'b0);

        // Zero-length start.
        start_xfer(10'h055, 11'd0, 1'b0, t0);
        observe(t0, 6, 1'b0, fv, lc, dc, sbz, svz);
        chk("zero_len_done_cycle", 64'(dc), 64'd1);
        chk("zero_len_busy_seen", sbz, 1'b0);
        chk("zero_len_valid_seen", svz, 1'b0);

        // Asynchronous reset in the middle of a transfer.
        start_xfer(10'h080, 11'd8, 1'b0, t0);
        while (cyc < t0 + 4) begin
            @(posedge clk);
            #1;
        end
        #2 reset_in = 1'b0;
        #1;
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_valid", out_valid, 1'b0);
        chk("async_rst_done", done, 1'b0);
        chk("async_rst_data", out_data, 32'h0);
        chk("async_rst_addr", ram_address_b, 10'h0);
        repeat (2) @(posedge clk);
        #3 reset_in = 1'b1;
        start_xfer(10'h090, 11'd2, 1'b0, t0);
        observe(t0, 10, 1'b1, fv, lc, dc, sbz, svz);
        chk("post_rst_first_valid_cycle", 64'(fv), 64'd3);
        chk("post_rst_done_cycle", 64'(dc), 64'd5);
        wait_idle(1'b0);

        // Randomized transfers over random RAM contents with random backpressure.
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        rmode = 2;
        for (int n = 0; n < 24; n++) begin
            a = 10'($urandom_range(0, 1023));
            if (n % 4 == 0) a = 10'($urandom_range(1000, 1023));
            l = 11'($urandom_range(1, 40));
            if (n % 7 == 3) l = 11'd0;
            start_xfer(a, l, 1'($urandom_range(0, 1)), t0);
            wait_idle(1'b1);
        end
        rmode = 0;
        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
